// File: rtl/demux3_bank.sv
// ----------------------------------------------------------------------------
// demux3_bank
//
// Eight-lane registered demultiplexer bank with single-lane writes and an
// eight-cycle broadcast sequencer.
//
// A single write (wr) loads one lane chosen by `control`. A broadcast (bcast)
// captures the input word into a hold register. The block then writes that
// word into lanes 0..7, one lane per cycle. Each lane has a valid flag that
// the consumer clears with its ack bit. Protocol violations set a sticky err
// flag, which only reset clears. Violations are overruns, requests while
// busy, and wr together with bcast.
//
// Ports
//   clk      : clock, all state changes on its rising edge
//   reset    : synchronous, active-high reset
//   in       : write data (WIDTH)
//   control  : target lane for single writes (3)
//   wr       : single-lane write request
//   bcast    : broadcast start request
//   ack      : per-lane consume strobe (8)
//   o0..o7   : registered lane data (WIDTH each)
//   valid    : per-lane data-present flags (8)
//   busy     : high while a broadcast is in progress
//   err      : sticky protocol-error flag
// ----------------------------------------------------------------------------
module demux3_bank #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] in,
   input  logic [2:0]       control,
   input  logic             wr,
   input  logic             bcast,
   input  logic [7:0]       ack,
   output logic [WIDTH-1:0] o0,
   output logic [WIDTH-1:0] o1,
   output logic [WIDTH-1:0] o2,
   output logic [WIDTH-1:0] o3,
   output logic [WIDTH-1:0] o4,
   output logic [WIDTH-1:0] o5,
   output logic [WIDTH-1:0] o6,
   output logic [WIDTH-1:0] o7,
   output logic [7:0]       valid,
   output logic             busy,
   output logic             err
);

   typedef enum logic {
      IDLE  = 1'b0,
      BCAST = 1'b1
   } state_t;

   state_t           state_q, state_d;
   logic [2:0]       cnt_q, cnt_d;
   logic [WIDTH-1:0] hold_q, hold_d;
   logic [7:0]       valid_q, valid_d;
   logic             err_q, err_d;
   logic [WIDTH-1:0] lane_q [8];

   logic [7:0]       we;         // one-hot lane write strobe for this edge
   logic [WIDTH-1:0] wdata;      // word written into the strobed lane
   logic             proto_err;  // request arrived when it must be refused
   logic             overrun;    // write landed on unconsumed data

   // Next-state and lane write selection
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      hold_d    = hold_q;
      we        = 8'h00;
      wdata     = in;
      proto_err = 1'b0;

      case (state_q)
         IDLE: begin
            if (bcast) begin
               // bcast wins; a simultaneous wr is dropped and flagged
               hold_d    = in;
               cnt_d     = 3'd0;
               state_d   = BCAST;
               proto_err = wr;
            end else if (wr) begin
               we = 8'h01 << control;
            end
         end
         BCAST: begin
            wdata     = hold_q;
            we        = 8'h01 << cnt_q;
            cnt_d     = cnt_q + 3'd1;   // wraps to 0 after lane 7
            proto_err = wr | bcast;
            if (cnt_q == 3'd7) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // A write coinciding with ack on the same lane is a clean hand-over, not
   // an overrun. Write takes priority over ack for the resulting valid bit.
   always_comb begin
      overrun = |(we & valid_q & ~ack);
      valid_d = (valid_q & ~ack) | we;
      err_d   = err_q | proto_err | overrun;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= 3'd0;
         hold_q  <= '0;
         valid_q <= 8'h00;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         hold_q  <= hold_d;
         valid_q <= valid_d;
         err_q   <= err_d;
      end
   end

   // Lane data registers
   generate
      for (genvar gi = 0; gi < 8; gi++) begin : g_lane
         always_ff @(posedge clk) begin
            if (reset) begin
               lane_q[gi] <= '0;
            end else if (we[gi]) begin
               lane_q[gi] <= wdata;
            end
         end
      end
   endgenerate

   assign o0    = lane_q[0];
   assign o1    = lane_q[1];
   assign o2    = lane_q[2];
   assign o3    = lane_q[3];
   assign o4    = lane_q[4];
   assign o5    = lane_q[5];
   assign o6    = lane_q[6];
   assign o7    = lane_q[7];
   assign valid = valid_q;
   assign busy  = (state_q == BCAST);
   assign err   = err_q;

endmodule

// File: tb/tb_demux3_bank.sv
// ----------------------------------------------------------------------------
// tb_demux3_bank
//
// Directed testbench for demux3_bank. The driver applies one input vector
// per cycle on the falling edge. It queues hand-computed expectations tagged
// with the cycle at which they must hold. An independent monitor checks them
// on the falling edge after the corresponding rising edge.
// ----------------------------------------------------------------------------
module tb_demux3_bank;

   localparam int WIDTH = 16;

   logic             clk = 1'b0;
   logic             reset;
   logic [WIDTH-1:0] in;
   logic [2:0]       control;
   logic             wr;
   logic             bcast;
   logic [7:0]       ack;
   logic [WIDTH-1:0] o0, o1, o2, o3, o4, o5, o6, o7;
   logic [7:0]       valid;
   logic             busy;
   logic             err;

   demux3_bank #(.WIDTH(WIDTH)) dut (
      .clk     (clk),
      .reset   (reset),
      .in      (in),
      .control (control),
      .wr      (wr),
      .bcast   (bcast),
      .ack     (ack),
      .o0      (o0),
      .o1      (o1),
      .o2      (o2),
      .o3      (o3),
      .o4      (o4),
      .o5      (o5),
      .o6      (o6),
      .o7      (o7),
      .valid   (valid),
      .busy    (busy),
      .err     (err)
   );

   always #5 clk = ~clk;

   // Signal selectors for expectations
   localparam int K_VALID = 8;
   localparam int K_BUSY  = 9;
   localparam int K_ERR   = 10;

   typedef struct {
      int          cyc;
      string       name;
      int          kind;
      logic [15:0] exp;
   } exp_t;

   exp_t q[$];
   int   cyc    = 0;
   int   checks = 0;
   int   errors = 0;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [15:0] sample(int kind);
      case (kind)
         0:       return o0;
         1:       return o1;
         2:       return o2;
         3:       return o3;
         4:       return o4;
         5:       return o5;
         6:       return o6;
         7:       return o7;
         K_VALID: return {8'h00, valid};
         K_BUSY:  return {15'd0, busy};
         default: return {15'd0, err};
      endcase
   endfunction

   // Monitor: compare every expectation due at this cycle
   always @(negedge clk) begin
      while (q.size() > 0 && q[0].cyc <= cyc) begin
         exp_t e;
         logic [15:0] act;
         e = q.pop_front();
         checks++;
         if (e.cyc < cyc) begin
            errors++;
            $display("FAIL %s not sampled at cycle %0d (now %0d)", e.name, e.cyc, cyc);
         end else begin
            act = sample(e.kind);
            if (act !== e.exp) begin
               errors++;
               $display("FAIL %s got %h want %h", e.name, act, e.exp);
            end else begin
               $display("ok   %s = %h", e.name, act);
            end
         end
      end
   end

   // Apply one vector; it is sampled on the next rising edge
   task automatic drive(input logic r, input logic w, input logic b,
                        input logic [2:0] c, input logic [15:0] d,
                        input logic [7:0] a);
      @(negedge clk);
      reset   = r;
      wr      = w;
      bcast   = b;
      control = c;
      in      = d;
      ack     = a;
   endtask

   task automatic idle();
      drive(1'b0, 1'b0, 1'b0, 3'd0, 16'h0000, 8'h00);
   endtask

   // Expectation for the state right after the edge of the last drive
   task automatic expect_after(input string name, input int kind, input logic [15:0] v);
      exp_t e;
      e.cyc  = cyc + 1;
      e.name = name;
      e.kind = kind;
      e.exp  = v;
      q.push_back(e);
   endtask

   initial begin
      reset = 1'b1; wr = 1'b0; bcast = 1'b0; control = 3'd0; in = '0; ack = 8'h00;

      // Reset state
      drive(1'b1, 1'b1, 1'b1, 3'd2, 16'hFFFF, 8'hFF);
      drive(1'b1, 1'b0, 1'b0, 3'd0, 16'h0000, 8'h00);
      expect_after("rst_valid", K_VALID, 16'h0000);
      expect_after("rst_busy",  K_BUSY,  16'h0000);
      expect_after("rst_err",   K_ERR,   16'h0000);
      expect_after("rst_o0",    0,       16'h0000);

      // Single write
      drive(1'b0, 1'b1, 1'b0, 3'd3, 16'h00A5, 8'h00);
      expect_after("wr3_o3",    3,       16'h00A5);
      expect_after("wr3_valid", K_VALID, 16'h0008);
      expect_after("wr3_err",   K_ERR,   16'h0000);

      // Ack/write collision on lane 2
      drive(1'b0, 1'b1, 1'b0, 3'd2, 16'h1111, 8'h00);
      expect_after("wr2_valid", K_VALID, 16'h000C);
      drive(1'b0, 1'b1, 1'b0, 3'd2, 16'hBEEF, 8'h04);
      expect_after("coll_o2",    2,       16'hBEEF);
      expect_after("coll_valid", K_VALID, 16'h000C);
      expect_after("coll_err",   K_ERR,   16'h0000);
      drive(1'b0, 1'b0, 1'b0, 3'd0, 16'h0000, 8'h04);
      expect_after("ack2_valid", K_VALID, 16'h0008);
      drive(1'b0, 1'b0, 1'b0, 3'd0, 16'h0000, 8'h48);  // lane 6 empty: no effect
      expect_after("ack36_valid", K_VALID, 16'h0000);
      expect_after("ack36_err",   K_ERR,   16'h0000);

      // Broadcast
      drive(1'b0, 1'b0, 1'b1, 3'd0, 16'h1234, 8'h00);
      expect_after("bc_start_busy",  K_BUSY,  16'h0001);
      expect_after("bc_start_valid", K_VALID, 16'h0000);
      for (int k = 1; k <= 8; k++) begin
         idle();
         expect_after($sformatf("bc_valid_%0d", k), K_VALID, 16'((1 << k) - 1));
         expect_after($sformatf("bc_busy_%0d", k),  K_BUSY,  (k < 8) ? 16'h0001 : 16'h0000);
      end
      idle();
      for (int k = 0; k < 8; k++) begin
         expect_after($sformatf("bc_o%0d", k), k, 16'h1234);
      end
      expect_after("bc_err", K_ERR, 16'h0000);

      // Busy conflict: wr during broadcast is ignored and flagged
      drive(1'b0, 1'b0, 1'b0, 3'd0, 16'h0000, 8'hFF);
      expect_after("clr_valid", K_VALID, 16'h0000);
      drive(1'b0, 1'b0, 1'b1, 3'd0, 16'h5555, 8'h00);
      drive(1'b0, 1'b1, 1'b0, 3'd0, 16'hFFFF, 8'h00);
      expect_after("busywr_o0",  0,     16'h5555);
      expect_after("busywr_err", K_ERR, 16'h0001);
      repeat (7) idle();
      expect_after("busywr_o7",   7,      16'h5555);
      expect_after("busywr_busy", K_BUSY, 16'h0000);

      // wr together with bcast in IDLE: broadcast wins
      drive(1'b0, 1'b0, 1'b0, 3'd0, 16'h0000, 8'hFF);
      drive(1'b0, 1'b1, 1'b1, 3'd1, 16'hAAAA, 8'h00);
      expect_after("both_busy",  K_BUSY,  16'h0001);
      expect_after("both_valid", K_VALID, 16'h0000);
      expect_after("both_err",   K_ERR,   16'h0001);
      repeat (8) idle();
      expect_after("both_o1",    1,       16'hAAAA);
      expect_after("both_o0",    0,       16'hAAAA);
      expect_after("both_vfull", K_VALID, 16'h00FF);

      // Overrun after a fresh reset; err is sticky
      drive(1'b1, 1'b0, 1'b0, 3'd0, 16'h0000, 8'h00);
      expect_after("rst2_err", K_ERR, 16'h0000);
      drive(1'b0, 1'b1, 1'b0, 3'd5, 16'h0001, 8'h00);
      expect_after("ovr1_valid", K_VALID, 16'h0020);
      expect_after("ovr1_err",   K_ERR,   16'h0000);
      drive(1'b0, 1'b1, 1'b0, 3'd5, 16'h0002, 8'h00);
      expect_after("ovr2_o5",  5,     16'h0002);
      expect_after("ovr2_err", K_ERR, 16'h0001);
      drive(1'b0, 1'b0, 1'b0, 3'd0, 16'h0000, 8'hFF);
      expect_after("ovr_sticky", K_ERR, 16'h0001);

      // Reset mid-broadcast on the 4th busy cycle
      drive(1'b1, 1'b0, 1'b0, 3'd0, 16'h0000, 8'h00);
      drive(1'b0, 1'b0, 1'b1, 3'd0, 16'h7777, 8'h00);
      idle();
      idle();
      idle();
      expect_after("mid_valid", K_VALID, 16'h0007);
      expect_after("mid_busy",  K_BUSY,  16'h0001);
      drive(1'b1, 1'b0, 1'b0, 3'd0, 16'h0000, 8'h00);
      expect_after("abort_valid", K_VALID, 16'h0000);
      expect_after("abort_busy",  K_BUSY,  16'h0000);
      expect_after("abort_o0",    0,       16'h0000);
      expect_after("abort_o7",    7,       16'h0000);
      expect_after("abort_err",   K_ERR,   16'h0000);
      // First edge with reset low is accepted
      drive(1'b0, 1'b1, 1'b0, 3'd6, 16'h0042, 8'h00);
      expect_after("post_o6",    6,       16'h0042);
      expect_after("post_valid", K_VALID, 16'h0040);
      expect_after("post_busy",  K_BUSY,  16'h0000);

      // Drain the scoreboard with a bounded wait
      for (int t = 0; t < 4 && q.size() > 0; t++) idle();
      if (q.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL drain %0d expectations left, want 0", q.size());
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
